// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MIPS core pipeline control blocks.
//   - TNEW_W and the TUSE_* / TNEW_* stage-distance constants.
//   - Default multiply/divide unit latencies.
//   - hazard_slot_t: per-stage shadow of {valid, destination, Tnew}.
//   - Helpers for Tnew ageing and per-slot hazard matching.
package mips_pkg;

    localparam int TNEW_W = 2;

    // Tuse: cycles until the operand is consumed, counted from D.
    localparam logic [TNEW_W-1:0] TUSE_D = 2'd0;
    localparam logic [TNEW_W-1:0] TUSE_E = 2'd1;
    localparam logic [TNEW_W-1:0] TUSE_M = 2'd2;

    // Tnew: cycles until the result can be bypassed, counted from E.
    localparam logic [TNEW_W-1:0] TNEW_LINK = 2'd0;
    localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic              valid;
        logic [4:0]        a3;
        logic [TNEW_W-1:0] tnew;
    } hazard_slot_t;

    // Tnew ages by one per stage but never goes below zero.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // A slot blocks a reader when it will write the register later than
    // the reader needs it. The src != 0 guard lives with the caller.
    function automatic logic slot_hazard(input hazard_slot_t      s,
                                         input logic [4:0]        src,
                                         input logic [TNEW_W-1:0] tuse);
        return s.valid && (s.a3 == src) && (s.tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt
//   Busy countdown for the multiply/divide unit.
//   Ports:
//     clk      in  : rising-edge clock
//     reset_n  in  : asynchronous active-low reset
//     start_E  in  : a valid mult/multu/div/divu sits in E this cycle
//     div_E    in  : the start in E is a divide (selects DIV_CYCLES)
//     md_busy  out : counter non-zero, or a start instruction in E
module md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_E,
    input  logic div_E,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt;

    // A start in E reloads the counter even if it has not drained yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (start_E) begin
            cnt <= div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // The start in E counts as busy so a following md op in D waits
    // before the counter has been loaded.
    assign md_busy = (cnt != '0) || start_E;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl
//   Producer-readiness hazard controller for the 5-stage MIPS pipeline.
//   Keeps shadow {valid, A3, Tnew} slots for E and M, tracks the md unit
//   busy window, and raises stall (hold PC and IF/ID) and flush_E (bubble
//   into ID/EX) in the same cycle the hazard is visible.
//   Ports:
//     clk, reset_n              : clock, asynchronous active-low reset
//     rs_D, rt_D                : source register fields in D
//     use_rs_D, use_rt_D        : instruction in D reads that source
//     Tuse_rs_D, Tuse_rt_D      : cycles until the operand is consumed
//     A3_D, Tnew_D              : destination and Tnew of the instruction in D
//     md_op_D, md_start_D       : md access / md start in D
//     md_div_D                  : start in D is a divide
//     stall, flush_E            : hazard detected (identical signals)
//     md_busy                   : md unit busy
//     stall_cnt                 : saturating count of stalled cycles
module stall_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        rs_D,
    input  logic [4:0]        rt_D,
    input  logic              use_rs_D,
    input  logic              use_rt_D,
    input  logic [TNEW_W-1:0] Tuse_rs_D,
    input  logic [TNEW_W-1:0] Tuse_rt_D,
    input  logic [4:0]        A3_D,
    input  logic [TNEW_W-1:0] Tnew_D,
    input  logic              md_op_D,
    input  logic              md_start_D,
    input  logic              md_div_D,
    output logic              stall,
    output logic              flush_E,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    hazard_slot_t e_slot;
    hazard_slot_t m_slot;
    logic         e_md_start;
    logic         e_md_div;

    logic         rs_haz;
    logic         rt_haz;
    logic         md_haz;

    always_comb begin
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        if (use_rs_D && (rs_D != 5'd0)) begin
            rs_haz = slot_hazard(e_slot, rs_D, Tuse_rs_D) ||
                     slot_hazard(m_slot, rs_D, Tuse_rs_D);
        end
        if (use_rt_D && (rt_D != 5'd0)) begin
            rt_haz = slot_hazard(e_slot, rt_D, Tuse_rt_D) ||
                     slot_hazard(m_slot, rt_D, Tuse_rt_D);
        end
        md_haz = md_op_D && md_busy;
    end

    assign stall   = rs_haz || rt_haz || md_haz;
    assign flush_E = stall;

    // E takes the D instruction unless stalled, in which case it becomes a
    // bubble. M always ages whatever E held; W needs no tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_slot     <= '0;
            m_slot     <= '0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
        end else begin
            if (stall) begin
                e_slot     <= '0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end else begin
                e_slot.valid <= 1'b1;
                e_slot.a3    <= A3_D;
                e_slot.tnew  <= Tnew_D;
                e_md_start   <= md_start_D;
                e_md_div     <= md_div_D;
            end
            m_slot.valid <= e_slot.valid;
            m_slot.a3    <= e_slot.a3;
            m_slot.tnew  <= sat_dec(e_slot.tnew);
        end
    end

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .start_E (e_slot.valid && e_md_start),
        .div_E   (e_md_div),
        .md_busy (md_busy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl
//   Scoreboard bench for stall_ctrl. The driver issues instructions into D,
//   predicts stall / md_busy / stall_cnt from a timeline model (each producer
//   has a "result ready" cycle, the md unit a "free after" cycle) and pushes
//   the prediction; the monitor pops and compares on each falling edge.
module tb_stall_ctrl;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;
    localparam int PW     = 8;
    localparam int CNT_MAX = (1 << PW) - 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [4:0]      rs_D = '0, rt_D = '0, A3_D = '0;
    logic            use_rs_D = 1'b0, use_rt_D = 1'b0;
    logic [1:0]      Tuse_rs_D = '0, Tuse_rt_D = '0, Tnew_D = '0;
    logic            md_op_D = 1'b0, md_start_D = 1'b0, md_div_D = 1'b0;
    logic            stall, flush_E, md_busy;
    logic [PW-1:0]   stall_cnt;

    always #5 clk = ~clk;

    stall_ctrl #(
        .MULT_CYCLES (MULT_C),
        .DIV_CYCLES  (DIV_C),
        .CNT_W       (4),
        .PERF_W      (PW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .use_rs_D   (use_rs_D),
        .use_rt_D   (use_rt_D),
        .Tuse_rs_D  (Tuse_rs_D),
        .Tuse_rt_D  (Tuse_rt_D),
        .A3_D       (A3_D),
        .Tnew_D     (Tnew_D),
        .md_op_D    (md_op_D),
        .md_start_D (md_start_D),
        .md_div_D   (md_div_D),
        .stall      (stall),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        int rs, rt;
        bit use_rs, use_rt;
        int tuse_rs, tuse_rt;
        int a3, tnew;
        bit md_op, md_start, md_div;
    } instr_t;

    typedef struct { int r; int e; int ready; } prod_t;
    typedef struct { bit st; bit mb; int cnt; } exp_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     md_free_at = -1000;
    int     m_cnt   = 0;
    prod_t  prod[$];
    exp_t   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic instr_t nop();
        instr_t i;
        i = '{rs:0, rt:0, use_rs:0, use_rt:0, tuse_rs:0, tuse_rt:0,
              a3:0, tnew:0, md_op:0, md_start:0, md_div:0};
        return i;
    endfunction

    function automatic instr_t alu(input int d, input int s, input int t);
        instr_t i = nop();
        i.rs = s; i.rt = t; i.use_rs = 1; i.use_rt = 1;
        i.tuse_rs = 1; i.tuse_rt = 1; i.a3 = d; i.tnew = 1;
        return i;
    endfunction

    function automatic instr_t lw(input int d, input int s);
        instr_t i = nop();
        i.rs = s; i.use_rs = 1; i.tuse_rs = 1; i.a3 = d; i.tnew = 2;
        return i;
    endfunction

    function automatic instr_t beq(input int s, input int t);
        instr_t i = nop();
        i.rs = s; i.rt = t; i.use_rs = 1; i.use_rt = 1;
        return i;
    endfunction

    function automatic instr_t jal();
        instr_t i = nop();
        i.a3 = 31; i.tnew = 0;
        return i;
    endfunction

    function automatic instr_t md_start(input int s, input int t, input bit dv);
        instr_t i = nop();
        i.rs = s; i.rt = t; i.use_rs = 1; i.use_rt = 1;
        i.tuse_rs = 1; i.tuse_rt = 1;
        i.md_op = 1; i.md_start = 1; i.md_div = dv;
        return i;
    endfunction

    function automatic instr_t mf(input int d);
        instr_t i = nop();
        i.a3 = d; i.tnew = 1; i.md_op = 1;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        int r1 = $urandom_range(0, 3);
        int r2 = $urandom_range(0, 3);
        int r3 = $urandom_range(0, 3);
        case ($urandom_range(0, 7))
            0, 1:    return alu(r1, r2, r3);
            2:       return lw(r1, r2);
            3:       return beq(r2, r3);
            4:       return jal();
            5:       return md_start(r2, r3, 1'($urandom_range(0, 1)));
            6:       return mf(r1);
            default: return nop();
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Operand read at cycle cyc+tuse; producer result usable from cycle
    // `ready`. Only producers that entered E this cycle or last are visible.
    function automatic bit src_haz(input bit u, input int r, input int tuse);
        if (!u || r == 0) return 1'b0;
        foreach (prod[k]) begin
            if (prod[k].r == r && (prod[k].e == cyc || prod[k].e == cyc - 1) &&
                prod[k].ready > cyc + tuse)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_busy();
        return md_free_at >= cyc;
    endfunction

    function automatic bit model_stall(input instr_t i);
        return src_haz(i.use_rs, i.rs, i.tuse_rs) ||
               src_haz(i.use_rt, i.rt, i.tuse_rt) ||
               (i.md_op && model_busy());
    endfunction

    task automatic apply(input instr_t i);
        rs_D = 5'(i.rs); rt_D = 5'(i.rt);
        use_rs_D = i.use_rs; use_rt_D = i.use_rt;
        Tuse_rs_D = 2'(i.tuse_rs); Tuse_rt_D = 2'(i.tuse_rt);
        A3_D = 5'(i.a3); Tnew_D = 2'(i.tnew);
        md_op_D = i.md_op; md_start_D = i.md_start; md_div_D = i.md_div;
    endtask

    // One cycle with i in D: entered at posedge+1, leaves at next posedge+1.
    task automatic drive_cycle(input instr_t i, output bit st, output bit obs);
        exp_t e;
        apply(i);
        st = model_stall(i);
        e = '{st: st, mb: model_busy(), cnt: m_cnt};
        exp_q.push_back(e);
        @(negedge clk);
        obs = stall;
        @(posedge clk);
        if (!st) begin
            if (i.a3 != 0) prod.push_back('{r: i.a3, e: cyc + 1, ready: cyc + 1 + i.tnew});
            if (i.md_start) md_free_at = cyc + 1 + (i.md_div ? DIV_C : MULT_C);
        end
        if (st && m_cnt != CNT_MAX) m_cnt++;
        cyc++;
        while (prod.size() > 0 && prod[0].e < cyc - 1) void'(prod.pop_front());
        #1;
    endtask

    task automatic issue(input instr_t i, output int n_obs);
        bit st, obs;
        int guard = 0;
        n_obs = 0;
        do begin
            drive_cycle(i, st, obs);
            if (obs) n_obs++;
            guard++;
        end while (st && guard < 40);
        if (st) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got %0d stall cycles required < 40", guard);
        end
    endtask

    task automatic drain();
        int n;
        issue(nop(), n);
        issue(nop(), n);
    endtask

    task automatic do_reset();
        exp_t e;
        reset_n = 1'b0;
        #1;
        prod.delete();
        md_free_at = -1000;
        m_cnt = 0;
        e = '{st: 1'b0, mb: 1'b0, cnt: 0};
        exp_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        cyc++;
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",     32'(stall),     32'(e.st));
                check("flush_E",   32'(flush_E),   32'(e.st));
                check("md_busy",   32'(md_busy),   32'(e.mb));
                check("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        int  n;
        bit  st, obs;
        @(posedge clk);
        #1;
        do_reset();

        // Load to $1 followed by a branch on $1: two stall cycles.
        issue(lw(1, 0), n);
        issue(beq(1, 2), n);
        check("lw_beq_stalls", 32'(n), 32'd2);
        check("lw_beq_cnt", 32'(stall_cnt), 32'd2);
        drain();

        // ALU to ALU reader: no stall; ALU to branch: one stall.
        issue(alu(3, 0, 0), n);
        issue(alu(4, 3, 0), n);
        check("alu_alu_stalls", 32'(n), 32'd0);
        drain();
        issue(alu(3, 0, 0), n);
        issue(beq(0, 3), n);
        check("alu_beq_stalls", 32'(n), 32'd1);
        drain();

        // Load to dependent ALU op: one stall.
        issue(lw(5, 0), n);
        issue(alu(6, 5, 0), n);
        check("lw_alu_stalls", 32'(n), 32'd1);
        drain();

        // Writer to $0 never blocks a $0 reader.
        issue(lw(0, 0), n);
        issue(beq(0, 0), n);
        check("zero_reg_stalls", 32'(n), 32'd0);
        drain();

        // mult then mflo: stalls t..t+5, issues at t+6.
        issue(md_start(1, 2, 1'b0), n);
        issue(mf(7), n);
        check("mult_mflo_stalls", 32'(n), 32'(MULT_C + 1));
        drain();

        // div then mult: 11 stalls, then mult reloads to MULT_CYCLES.
        issue(md_start(1, 2, 1'b1), n);
        issue(md_start(1, 2, 1'b0), n);
        check("div_mult_stalls", 32'(n), 32'(DIV_C + 1));
        issue(mf(8), n);
        check("reload_mfhi_stalls", 32'(n), 32'(MULT_C + 1));
        drain();

        // Reset while E holds a load to $1 and a reader is stalled.
        issue(lw(1, 0), n);
        drive_cycle(alu(2, 1, 0), st, obs);
        check("pre_reset_stall", 32'(obs), 32'd1);
        do_reset();
        issue(alu(2, 1, 0), n);
        check("post_reset_stalls", 32'(n), 32'd0);

        // Reset mid md-stall discards outstanding md work.
        issue(md_start(1, 2, 1'b1), n);
        drive_cycle(mf(3), st, obs);
        do_reset();
        issue(mf(3), n);
        check("md_reset_stalls", 32'(n), 32'd0);
        drain();

        // Randomized instruction stream.
        for (int k = 0; k < 2000; k++) begin
            issue(rand_instr(), n);
        end
        drain();

        // Drive well past 2^PW stalled cycles; the counter must hold at all-ones.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            issue(md_start(0, 0, 1'b1), n);
            issue(mf(1), n);
        end
        check("stall_cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
